tlb_walk_responder: RTL and testbench
=====================================

TLB_WALK_RESPONDER -- requirements
Module: tlb_walk_responder

Interface
REQ-001 SHALL have parameters: DATA_WIDTH = 32 (PTE/data width); ADDR_WIDTH = 32 (address width); PPN_LEN = 22 (root/PTE PPN width).
REQ-002 SHALL have one clock and a synchronous, active-low reset; ports are named CLK and RST as elsewhere in the codebase.
REQ-003 CLK  in  1  sole clock; all state changes on rising edge.
REQ-004 RST  in  1  synchronous active-low reset; sampled on the CLK rising edge.
REQ-005 FLUSH  in  1  abort the current walk.
REQ-006 SATP_PPN  in  PPN_LEN  root page-table PPN.
REQ-007 ADDR_IN_VALID  in  1  single-cycle miss request from the ITLB.
REQ-008 ADDR_IN  in  ADDR_WIDTH  missing virtual address.
REQ-009 BUSY  out  1  walk in progress.
REQ-010 DATA_OUT_VALID  out  1  single-cycle refill pulse.
REQ-011 DATA_OUT  out  DATA_WIDTH  leaf PTE; PPN in [31:10].
REQ-012 PAGE_FAULT  out  1  qualifies DATA_OUT_VALID.
REQ-013 MEM_REQ_VALID  out  1  PTE read request.
REQ-014 MEM_REQ_READY  in  1  memory accepts the request.
REQ-015 MEM_REQ_ADDR  out  ADDR_WIDTH  PTE physical address.
REQ-016 MEM_RESP_VALID  in  1  PTE data valid.
REQ-017 MEM_RESP_DATA  in  DATA_WIDTH  PTE read data.

Function
REQ-018 SHALL implement the states IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, RESP and DRAIN.
REQ-019 In IDLE, ADDR_IN_VALID SHALL latch ADDR_IN into va and go to L1_REQ; MEM_REQ_VALID SHALL assert the next cycle.
REQ-020 ADDR_IN_VALID outside IDLE SHALL be ignored; BUSY = (state != IDLE).
REQ-021 In L1_REQ, MEM_REQ_ADDR SHALL be {SATP_PPN[19:0], va[31:22], 2'b00}, with the PA truncated to 32 bits.
REQ-022 In L0_REQ, MEM_REQ_ADDR SHALL be {pte[29:10], va[21:12], 2'b00}.
REQ-023 MEM_REQ_VALID SHALL be held, with the address stable, until MEM_REQ_READY is sampled high; the state then moves to the matching WAIT state.
REQ-024 In a WAIT state, MEM_RESP_VALID SHALL latch MEM_RESP_DATA as pte and evaluate it; MEM_RESP_VALID in any other state SHALL be ignored.
REQ-025 Invalid PTE: V=0, or (R=0 & W=1), SHALL give a fault.
REQ-026 Leaf PTE (R|X) with X=0 SHALL give a fault (fetch-only walker).
REQ-027 Non-leaf PTE at L1 SHALL go to L0_REQ; non-leaf PTE at L0 SHALL give a fault.
REQ-028 Leaf PTE at L1 with pte[19:10] != 0 SHALL give a fault (misaligned superpage).
REQ-029 Leaf PTE at L1 without fault SHALL return DATA_OUT = pte with [19:10] replaced by va[21:12].
REQ-030 Leaf PTE at L0 without fault SHALL return DATA_OUT = pte unchanged.
REQ-031 RESP SHALL last one cycle: DATA_OUT_VALID=1, PAGE_FAULT set per the evaluation, then IDLE.
REQ-032 On a fault, DATA_OUT SHALL be 0.
REQ-033 Latency from the final MEM_RESP_VALID to DATA_OUT_VALID SHALL be exactly 1 cycle.
REQ-034 FLUSH in L1_REQ or L0_REQ before the handshake, or in IDLE/RESP, SHALL go to IDLE with no DATA_OUT_VALID.
REQ-035 FLUSH in L1_WAIT or L0_WAIT SHALL go to DRAIN; DRAIN waits for MEM_RESP_VALID, discards it, then goes to IDLE.
REQ-036 FLUSH on the same cycle as the handshake SHALL treat the request as outstanding and go to DRAIN.
REQ-037 FLUSH together with MEM_RESP_VALID in a WAIT state SHALL discard the data and go to IDLE.
REQ-038 DATA_OUT and PAGE_FAULT SHALL be 0 whenever DATA_OUT_VALID=0.

Reset
REQ-039 RST=0 SHALL force IDLE, BUSY=0, MEM_REQ_VALID=0, DATA_OUT_VALID=0, PAGE_FAULT=0, DATA_OUT=0, MEM_REQ_ADDR=0, va=0 and pte=0.
REQ-040 Reset mid-walk SHALL abandon the walk without DRAIN; the memory side is reset by the same RST.

Configuration
REQ-041 With PTW_AD_CHECK_EN defined, a leaf PTE with A (bit 6) = 0 SHALL give a fault.
REQ-042 Without PTW_AD_CHECK_EN, A and D SHALL be ignored.

Verification
REQ-043 Two-level walk: SATP_PPN=22'h100, ADDR_IN=32'h0040_1234 -> request 0x0010_0004; respond 0x0008_0001 -> request 0x0020_0004; respond 0x2000_004B -> DATA_OUT=0x2000_004B, PAGE_FAULT=0, one cycle after the response.
REQ-044 Superpage: same VA; L1 responds 0x2000_004B -> no L0 request; DATA_OUT=0x2000_044B.
REQ-045 Faults: L1 responds 0x2000_044B (misaligned) -> PAGE_FAULT=1, DATA_OUT=0; L1 responds 0x0000_0000 (V=0) -> fault; L0 responds 0x0008_0001 (non-leaf) -> fault.
REQ-046 Backpressure: MEM_REQ_READY low for 5 cycles -> MEM_REQ_VALID held with MEM_REQ_ADDR stable; a second ADDR_IN_VALID during the walk is ignored.
REQ-047 Flush: FLUSH in L1_WAIT -> DRAIN; the response is discarded with no DATA_OUT_VALID; a new request 2 cycles later walks correctly.
REQ-048 Config: leaf 0x2000_000B with PTW_AD_CHECK_EN -> PAGE_FAULT=1; without it -> DATA_OUT=0x2000_000B.

Source files
------------

// File: rtl/tlb_walk_responder_if.sv
// Bundles the ITLB miss/refill and PTE memory signals of the walker.
// The slave modport is taken by tlb_walk_responder; master by its environment.
interface tlb_walk_responder_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned PPN_LEN    = 22
);
  logic                  FLUSH;
  logic [PPN_LEN-1:0]    SATP_PPN;
  logic                  ADDR_IN_VALID;
  logic [ADDR_WIDTH-1:0] ADDR_IN;
  logic                  BUSY;
  logic                  DATA_OUT_VALID;
  logic [DATA_WIDTH-1:0] DATA_OUT;
  logic                  PAGE_FAULT;
  logic                  MEM_REQ_VALID;
  logic                  MEM_REQ_READY;
  logic [ADDR_WIDTH-1:0] MEM_REQ_ADDR;
  logic                  MEM_RESP_VALID;
  logic [DATA_WIDTH-1:0] MEM_RESP_DATA;

  modport slave (
    input  FLUSH, SATP_PPN, ADDR_IN_VALID, ADDR_IN, MEM_REQ_READY, MEM_RESP_VALID, MEM_RESP_DATA,
    output BUSY, DATA_OUT_VALID, DATA_OUT, PAGE_FAULT, MEM_REQ_VALID, MEM_REQ_ADDR
  );

  modport master (
    output FLUSH, SATP_PPN, ADDR_IN_VALID, ADDR_IN, MEM_REQ_READY, MEM_RESP_VALID, MEM_RESP_DATA,
    input  BUSY, DATA_OUT_VALID, DATA_OUT, PAGE_FAULT, MEM_REQ_VALID, MEM_REQ_ADDR
  );
endinterface

// File: rtl/tlb_walk_responder.sv
// Two-level Sv32 page-table walker serving instruction-fetch TLB misses.
// Define PTW_AD_CHECK_EN to fault on leaf PTEs whose Accessed bit is clear.
module tlb_walk_responder #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned PPN_LEN    = 22
) (
  input logic                 CLK,
  input logic                 RST,
  tlb_walk_responder_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    L1_REQ  = 3'd1,
    L1_WAIT = 3'd2,
    L0_REQ  = 3'd3,
    L0_WAIT = 3'd4,
    RESP    = 3'd5,
    DRAIN   = 3'd6
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] va;
  logic [DATA_WIDTH-1:0] pte;
  logic                  busy;
  logic                  mem_req_valid;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic                  data_out_valid;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  page_fault;

  // Decode of the PTE currently on the response bus.
  logic [DATA_WIDTH-1:0] rd;
  logic                  rd_invalid;
  logic                  rd_leaf;
  logic                  rd_ad_fault;
  logic                  rd_misaligned;
  logic                  l1_descend;
  logic                  l1_fault;
  logic                  l0_fault;
  logic [ADDR_WIDTH-1:0] l1_addr;
  logic [ADDR_WIDTH-1:0] l0_addr;
  logic [DATA_WIDTH-1:0] super_data;

  assign rd            = bus.MEM_RESP_DATA;
  assign rd_invalid    = !rd[0] || (!rd[1] && rd[2]);
  assign rd_leaf       = rd[1] || rd[3];
  assign rd_misaligned = (rd[19:10] != 10'd0);

`ifdef PTW_AD_CHECK_EN
  assign rd_ad_fault = !rd[6];
`else
  assign rd_ad_fault = 1'b0;
`endif

  assign l1_descend = !rd_invalid && !rd_leaf;
  assign l1_fault   = rd_invalid || (rd_leaf && (!rd[3] || rd_misaligned || rd_ad_fault));
  assign l0_fault   = rd_invalid || !rd_leaf || !rd[3] || rd_ad_fault;

  // L1 index comes straight from ADDR_IN so the request address is ready with MEM_REQ_VALID.
  assign l1_addr    = ADDR_WIDTH'({bus.SATP_PPN[19:0], bus.ADDR_IN[31:22], 2'b00});
  assign l0_addr    = ADDR_WIDTH'({rd[29:10], va[21:12], 2'b00});
  assign super_data = DATA_WIDTH'({rd[31:20], va[21:12], rd[9:0]});

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state          <= IDLE;
      va             <= '0;
      pte            <= '0;
      busy           <= 1'b0;
      mem_req_valid  <= 1'b0;
      mem_req_addr   <= '0;
      data_out_valid <= 1'b0;
      data_out       <= '0;
      page_fault     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.ADDR_IN_VALID && !bus.FLUSH) begin
            state         <= L1_REQ;
            va            <= bus.ADDR_IN;
            busy          <= 1'b1;
            mem_req_valid <= 1'b1;
            mem_req_addr  <= l1_addr;
          end
        end

        L1_REQ, L0_REQ: begin
          // A request accepted on the flush cycle is still owed a response.
          if (bus.MEM_REQ_READY) begin
            mem_req_valid <= 1'b0;
            if (bus.FLUSH)             state <= DRAIN;
            else if (state == L1_REQ)  state <= L1_WAIT;
            else                       state <= L0_WAIT;
          end else if (bus.FLUSH) begin
            mem_req_valid <= 1'b0;
            state         <= IDLE;
            busy          <= 1'b0;
          end
        end

        L1_WAIT: begin
          if (bus.MEM_RESP_VALID) begin
            if (bus.FLUSH) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else if (l1_descend) begin
              pte           <= rd;
              state         <= L0_REQ;
              mem_req_valid <= 1'b1;
              mem_req_addr  <= l0_addr;
            end else begin
              pte            <= rd;
              state          <= RESP;
              data_out_valid <= 1'b1;
              page_fault     <= l1_fault;
              data_out       <= l1_fault ? '0 : super_data;
            end
          end else if (bus.FLUSH) begin
            state <= DRAIN;
          end
        end

        L0_WAIT: begin
          if (bus.MEM_RESP_VALID) begin
            if (bus.FLUSH) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              pte            <= rd;
              state          <= RESP;
              data_out_valid <= 1'b1;
              page_fault     <= l0_fault;
              data_out       <= l0_fault ? '0 : rd;
            end
          end else if (bus.FLUSH) begin
            state <= DRAIN;
          end
        end

        RESP: begin
          state          <= IDLE;
          busy           <= 1'b0;
          data_out_valid <= 1'b0;
          data_out       <= '0;
          page_fault     <= 1'b0;
        end

        DRAIN: begin
          if (bus.MEM_RESP_VALID) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state          <= IDLE;
          busy           <= 1'b0;
          mem_req_valid  <= 1'b0;
          data_out_valid <= 1'b0;
          data_out       <= '0;
          page_fault     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.BUSY           = busy;
  assign bus.MEM_REQ_VALID  = mem_req_valid;
  assign bus.MEM_REQ_ADDR   = mem_req_addr;
  assign bus.DATA_OUT_VALID = data_out_valid;
  assign bus.DATA_OUT       = data_out;
  assign bus.PAGE_FAULT     = page_fault;

  // pte is kept as walk state for debug visibility; these bits feed no logic.
  logic unused_bits;
  assign unused_bits = ^{pte, va[11:0], va[31:22], bus.SATP_PPN[PPN_LEN-1:20]};

endmodule

// File: tb/tb_tlb_walk_responder.sv
// Scoreboarded bench for tlb_walk_responder: a task-driven PTE memory plus a refill monitor.
module tb_tlb_walk_responder;
  localparam int unsigned DW      = 32;
  localparam int unsigned AW      = 32;
  localparam int unsigned PL      = 22;
  localparam int unsigned TIMEOUT = 50;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  tlb_walk_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PPN_LEN(PL)) bus ();
  tlb_walk_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PPN_LEN(PL)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [32:0] exp_q[$];
  logic [32:0] exp_v;
  logic        mon_en = 1'b0;

  // Refill monitor: every DATA_OUT_VALID pulse must match the oldest expectation.
  always @(negedge CLK) begin
    if (mon_en) begin
      n_checks++;
      if (bus.DATA_OUT_VALID === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_refill: got data=%h fault=%b, required no DATA_OUT_VALID",
                   bus.DATA_OUT, bus.PAGE_FAULT);
        end else begin
          exp_v = exp_q.pop_front();
          if ({bus.PAGE_FAULT, bus.DATA_OUT} !== exp_v) begin
            n_fail++;
            $display("FAIL refill: got fault=%b data=%h, required fault=%b data=%h",
                     bus.PAGE_FAULT, bus.DATA_OUT, exp_v[32], exp_v[31:0]);
          end
        end
      end else if (bus.DATA_OUT_VALID !== 1'b0 || bus.DATA_OUT !== '0 || bus.PAGE_FAULT !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_outputs: got valid=%b data=%h fault=%b, required 0/0/0",
                 bus.DATA_OUT_VALID, bus.DATA_OUT, bus.PAGE_FAULT);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    n_checks++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic start_walk(input logic [31:0] va);
    bus.ADDR_IN_VALID = 1'b1;
    bus.ADDR_IN       = va;
    step();
    bus.ADDR_IN_VALID = 1'b0;
    bus.ADDR_IN       = '0;
  endtask

  // Memory side of one PTE read: wait for the request, stall READY, then respond.
  task automatic mem_xact(input logic [31:0] exp_addr, input int ready_wait,
                          input logic [31:0] resp, input int resp_wait, input string tag);
    int t = 0;
    while (bus.MEM_REQ_VALID !== 1'b1 && t < TIMEOUT) begin
      step();
      t++;
    end
    n_checks++;
    if (bus.MEM_REQ_VALID !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_req_timeout: MEM_REQ_VALID=%b, required 1", tag, bus.MEM_REQ_VALID);
      return;
    end
    chk({tag, "_addr"}, bus.MEM_REQ_ADDR, exp_addr);
    for (int i = 0; i < ready_wait; i++) begin
      step();
      chk({tag, "_hold_valid"}, 32'(bus.MEM_REQ_VALID), 32'd1);
      chk({tag, "_hold_addr"}, bus.MEM_REQ_ADDR, exp_addr);
    end
    bus.MEM_REQ_READY = 1'b1;
    step();
    bus.MEM_REQ_READY = 1'b0;
    chk({tag, "_valid_drop"}, 32'(bus.MEM_REQ_VALID), 32'd0);
    repeat (resp_wait) step();
    bus.MEM_RESP_VALID = 1'b1;
    bus.MEM_RESP_DATA  = resp;
    step();
    bus.MEM_RESP_VALID = 1'b0;
    bus.MEM_RESP_DATA  = '0;
  endtask

  task automatic run_walk(input logic [31:0] va, input logic [31:0] l1_addr, input logic [31:0] l1_resp,
                          input bit has_l0, input logic [31:0] l0_addr, input logic [31:0] l0_resp,
                          input logic exp_fault, input logic [31:0] exp_data, input string tag);
    exp_q.push_back({exp_fault, exp_data});
    start_walk(va);
    chk({tag, "_busy"}, 32'(bus.BUSY), 32'd1);
    mem_xact(l1_addr, 0, l1_resp, 1, {tag, "_l1"});
    if (has_l0) mem_xact(l0_addr, 0, l0_resp, 2, {tag, "_l0"});
    else        chk({tag, "_no_l0_req"}, 32'(bus.MEM_REQ_VALID), 32'd0);
    chk({tag, "_latency"}, 32'(bus.DATA_OUT_VALID), 32'd1);
    step();
    chk({tag, "_idle"}, 32'(bus.BUSY), 32'd0);
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (3) step();
    chk("rst_busy", 32'(bus.BUSY), 32'd0);
    chk("rst_req_valid", 32'(bus.MEM_REQ_VALID), 32'd0);
    chk("rst_req_addr", bus.MEM_REQ_ADDR, 32'd0);
    chk("rst_out_valid", 32'(bus.DATA_OUT_VALID), 32'd0);
    chk("rst_data", bus.DATA_OUT, 32'd0);
    chk("rst_fault", 32'(bus.PAGE_FAULT), 32'd0);
    RST    = 1'b1;
    mon_en = 1'b1;
    step();
  endtask

  task automatic test_two_level();
    bus.SATP_PPN = 22'h100;
    run_walk(32'h0040_1234, 32'h0010_0004, 32'h0008_0001, 1'b1, 32'h0020_0004, 32'h2000_004B,
             1'b0, 32'h2000_004B, "two_level");
    bus.SATP_PPN = 22'h30A5A5;
    run_walk(32'hFFC0_3000, 32'h0A5A_5FFC, 32'h0008_0001, 1'b1, 32'h0020_000C, 32'h1234_58CB,
             1'b0, 32'h1234_58CB, "two_level_hi");
  endtask

  task automatic test_superpage();
    bus.SATP_PPN = 22'h100;
    run_walk(32'h0040_1234, 32'h0010_0004, 32'h2000_004B, 1'b0, 32'h0, 32'h0,
             1'b0, 32'h2000_044B, "superpage");
    bus.SATP_PPN = 22'h30A5A5;
    run_walk(32'hFFC0_3000, 32'h0A5A_5FFC, 32'h2000_004B, 1'b0, 32'h0, 32'h0,
             1'b0, 32'h2000_0C4B, "superpage_hi");
  endtask

  task automatic test_faults();
    bus.SATP_PPN = 22'h100;
    run_walk(32'h0040_1234, 32'h0010_0004, 32'h2000_044B, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0, "f_misaligned");
    run_walk(32'h0040_1234, 32'h0010_0004, 32'h0000_0000, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0, "f_invalid");
    run_walk(32'h0040_1234, 32'h0010_0004, 32'h0000_0005, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0, "f_w_no_r");
    run_walk(32'h0040_1234, 32'h0010_0004, 32'h0008_0001, 1'b1, 32'h0020_0004, 32'h0008_0001,
             1'b1, 32'h0, "f_l0_nonleaf");
    run_walk(32'h0040_1234, 32'h0010_0004, 32'h0008_0001, 1'b1, 32'h0020_0004, 32'h2000_0043,
             1'b1, 32'h0, "f_no_exec");
  endtask

  task automatic test_backpressure();
    bus.SATP_PPN = 22'h100;
    exp_q.push_back({1'b0, 32'h2000_004B});
    start_walk(32'h0040_1234);
    bus.ADDR_IN_VALID = 1'b1;
    bus.ADDR_IN       = 32'hFFC0_3000;
    step();
    bus.ADDR_IN_VALID = 1'b0;
    chk("bp_busy", 32'(bus.BUSY), 32'd1);
    mem_xact(32'h0010_0004, 5, 32'h0008_0001, 3, "bp_l1");
    mem_xact(32'h0020_0004, 2, 32'h2000_004B, 0, "bp_l0");
    chk("bp_latency", 32'(bus.DATA_OUT_VALID), 32'd1);
    step();
    chk("bp_idle", 32'(bus.BUSY), 32'd0);
  endtask

  task automatic test_flush();
    bus.SATP_PPN = 22'h100;
    // flush while waiting for the L1 response: drain and drop it
    start_walk(32'h0040_1234);
    bus.MEM_REQ_READY = 1'b1; step(); bus.MEM_REQ_READY = 1'b0;
    bus.FLUSH = 1'b1; step(); bus.FLUSH = 1'b0;
    chk("fl_wait_drain_busy", 32'(bus.BUSY), 32'd1);
    step(); step();
    chk("fl_drain_no_req", 32'(bus.MEM_REQ_VALID), 32'd0);
    chk("fl_drain_still_busy", 32'(bus.BUSY), 32'd1);
    bus.MEM_RESP_VALID = 1'b1; bus.MEM_RESP_DATA = 32'h2000_004B; step();
    bus.MEM_RESP_VALID = 1'b0; bus.MEM_RESP_DATA = '0;
    chk("fl_drain_done", 32'(bus.BUSY), 32'd0);
    chk("fl_drain_no_refill", 32'(bus.DATA_OUT_VALID), 32'd0);
    step(); step();
    run_walk(32'h0040_1234, 32'h0010_0004, 32'h0008_0001, 1'b1, 32'h0020_0004, 32'h2000_004B,
             1'b0, 32'h2000_004B, "fl_after");
    // flush before the handshake
    start_walk(32'h0040_1234);
    bus.FLUSH = 1'b1; step(); bus.FLUSH = 1'b0;
    chk("fl_req_busy", 32'(bus.BUSY), 32'd0);
    chk("fl_req_valid", 32'(bus.MEM_REQ_VALID), 32'd0);
    // flush on the handshake cycle: request is outstanding
    start_walk(32'h0040_1234);
    bus.FLUSH = 1'b1; bus.MEM_REQ_READY = 1'b1; step();
    bus.FLUSH = 1'b0; bus.MEM_REQ_READY = 1'b0;
    chk("fl_hs_drain", 32'(bus.BUSY), 32'd1);
    bus.MEM_RESP_VALID = 1'b1; bus.MEM_RESP_DATA = 32'h0008_0001; step();
    bus.MEM_RESP_VALID = 1'b0; bus.MEM_RESP_DATA = '0;
    chk("fl_hs_idle", 32'(bus.BUSY), 32'd0);
    // flush together with the response
    start_walk(32'h0040_1234);
    bus.MEM_REQ_READY = 1'b1; step(); bus.MEM_REQ_READY = 1'b0;
    bus.FLUSH = 1'b1; bus.MEM_RESP_VALID = 1'b1; bus.MEM_RESP_DATA = 32'h2000_004B; step();
    bus.FLUSH = 1'b0; bus.MEM_RESP_VALID = 1'b0; bus.MEM_RESP_DATA = '0;
    chk("fl_resp_idle", 32'(bus.BUSY), 32'd0);
    chk("fl_resp_no_l0", 32'(bus.MEM_REQ_VALID), 32'd0);
    // reset mid-walk abandons it; a late response is ignored in IDLE
    start_walk(32'h0040_1234);
    bus.MEM_REQ_READY = 1'b1; step(); bus.MEM_REQ_READY = 1'b0;
    RST = 1'b0; step(); RST = 1'b1;
    chk("rst_mid_busy", 32'(bus.BUSY), 32'd0);
    chk("rst_mid_addr", bus.MEM_REQ_ADDR, 32'd0);
    bus.MEM_RESP_VALID = 1'b1; bus.MEM_RESP_DATA = 32'h2000_004B; step();
    bus.MEM_RESP_VALID = 1'b0; bus.MEM_RESP_DATA = '0;
    chk("rst_mid_stray", 32'(bus.BUSY), 32'd0);
    step();
  endtask

  task automatic test_config();
    bus.SATP_PPN = 22'h100;
`ifdef PTW_AD_CHECK_EN
    run_walk(32'h0040_1234, 32'h0010_0004, 32'h0008_0001, 1'b1, 32'h0020_0004, 32'h2000_000B,
             1'b1, 32'h0, "cfg_a_clear");
`else
    run_walk(32'h0040_1234, 32'h0010_0004, 32'h0008_0001, 1'b1, 32'h0020_0004, 32'h2000_000B,
             1'b0, 32'h2000_000B, "cfg_a_clear");
`endif
  endtask

  initial begin
    RST                = 1'b0;
    bus.FLUSH          = 1'b0;
    bus.SATP_PPN       = '0;
    bus.ADDR_IN_VALID  = 1'b0;
    bus.ADDR_IN        = '0;
    bus.MEM_REQ_READY  = 1'b0;
    bus.MEM_RESP_VALID = 1'b0;
    bus.MEM_RESP_DATA  = '0;

    test_reset();
    test_two_level();
    test_superpage();
    test_faults();
    test_backpressure();
    test_flush();
    test_config();
    step();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
